// File: rtl/alu_seq_if.sv
// Operand/result bundle between the execute-stage operand muxes and the ALU.
// No latency of its own; pure wiring.
// No backpressure: the requester watches Busy/Done, Start is ignored while Busy.
interface alu_seq_if #(
  parameter int WIDTH = 16
);
  logic             Start;
  logic [3:0]       Op;
  logic [WIDTH-1:0] Oprnd_A;
  logic [WIDTH-1:0] Oprnd_B;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Result;
  logic             Zro_Flag;
  logic             Neg_Flag;
  logic             Carry_Flag;
  logic             Ovf_Flag;

  // Requester side (operand muxes / testbench)
  modport master (
    output Start, Op, Oprnd_A, Oprnd_B,
    input  Busy, Done, Result, Zro_Flag, Neg_Flag, Carry_Flag, Ovf_Flag
  );

  // ALU side
  modport slave (
    input  Start, Op, Oprnd_A, Oprnd_B,
    output Busy, Done, Result, Zro_Flag, Neg_Flag, Carry_Flag, Ovf_Flag
  );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle add/sub/logic, bit-serial shifts, shift-add multiply.
// Latency: 1 edge for single-cycle ops, n edges for shifts by n, WIDTH edges for MUL/MULH.
// Backpressure: Busy high while iterating; Start is ignored until Busy drops.
module alu_seq #(
  parameter int WIDTH  = 16,
  parameter bit MUL_EN = 1'b1
) (
  input  logic      Clk,
  input  logic      Reset_N,
  alu_seq_if.slave  alu_if
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'd0,  OP_ADC  = 4'd1,  OP_SUB  = 4'd2,  OP_SBB = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4,  OP_OR   = 4'd5,  OP_XOR  = 4'd6,  OP_NOTA = 4'd7;
  localparam logic [3:0] OP_PASSB = 4'd8, OP_SHL  = 4'd9,  OP_SHR  = 4'd10, OP_SAR = 4'd11;
  localparam logic [3:0] OP_ROL  = 4'd12, OP_MUL  = 4'd13, OP_MULH = 4'd14;

  localparam logic [SHW:0] CNT_ONE = (SHW+1)'(1);
  localparam logic [SHW:0] CNT_MUL = (SHW+1)'(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, MUL} state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_result;
  logic               r_zro, r_neg, r_carry, r_ovf, r_done;
  logic [3:0]         r_op;
  logic [WIDTH-1:0]   r_sh;
  logic [SHW:0]       r_cnt;
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH-1:0]   r_mcand;

  state_t             w_state_nxt;
  logic               w_fin, w_c, w_v, w_load_sh, w_load_mul;
  logic [WIDTH-1:0]   w_res;
  logic [WIDTH-1:0]   w_alu_res;
  logic               w_alu_c, w_alu_v;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH-1:0]   w_sh_nxt;
  logic               w_sh_out;
  logic [WIDTH:0]     w_msum;
  logic [2*WIDTH-1:0] w_prod_nxt;
  logic               w_is_shift, w_is_mul;
  logic [SHW-1:0]     w_cnt;

  wire  [WIDTH-1:0]   w_a = alu_if.Oprnd_A;
  wire  [WIDTH-1:0]   w_b = alu_if.Oprnd_B;
  wire  [WIDTH:0]     w_cin = {{WIDTH{1'b0}}, r_carry};

  assign alu_if.Busy       = (r_state != IDLE);
  assign alu_if.Done       = r_done;
  assign alu_if.Result     = r_result;
  assign alu_if.Zro_Flag   = r_zro;
  assign alu_if.Neg_Flag   = r_neg;
  assign alu_if.Carry_Flag = r_carry;
  assign alu_if.Ovf_Flag   = r_ovf;

  assign w_cnt      = w_b[SHW-1:0];
  assign w_is_shift = (alu_if.Op == OP_SHL) || (alu_if.Op == OP_SHR) ||
                      (alu_if.Op == OP_SAR) || (alu_if.Op == OP_ROL);
  assign w_is_mul   = MUL_EN && ((alu_if.Op == OP_MUL) || (alu_if.Op == OP_MULH));

  // Single-cycle result from the live operands; carry-in is the currently latched Carry_Flag
  always_comb begin
    w_alu_res = '0;
    w_alu_c   = 1'b0;
    w_alu_v   = 1'b0;
    w_sum     = '0;
    case (alu_if.Op)
      OP_ADD, OP_ADC: begin
        w_sum     = {1'b0, w_a} + {1'b0, w_b} + ((alu_if.Op == OP_ADC) ? w_cin : '0);
        w_alu_res = w_sum[WIDTH-1:0];
        w_alu_c   = w_sum[WIDTH];
        w_alu_v   = (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1] != w_a[WIDTH-1]);
      end
      OP_SUB, OP_SBB: begin
        w_sum     = {1'b0, w_a} - {1'b0, w_b} - ((alu_if.Op == OP_SBB) ? w_cin : '0);
        w_alu_res = w_sum[WIDTH-1:0];
        w_alu_c   = w_sum[WIDTH];
        w_alu_v   = (w_a[WIDTH-1] != w_b[WIDTH-1]) && (w_sum[WIDTH-1] != w_a[WIDTH-1]);
      end
      OP_AND:   w_alu_res = w_a & w_b;
      OP_OR:    w_alu_res = w_a | w_b;
      OP_XOR:   w_alu_res = w_a ^ w_b;
      OP_NOTA:  w_alu_res = ~w_a;
      OP_PASSB: w_alu_res = w_b;
      // Only reached with a zero shift count: A passes through, C stays 0
      OP_SHL, OP_SHR, OP_SAR, OP_ROL: w_alu_res = w_a;
      // Reserved (and MUL/MULH when multiply is not built)
      default:  w_alu_res = '0;
    endcase
  end

  // One shift/rotate step on the working register, plus the bit that falls out
  always_comb begin
    w_sh_nxt = r_sh;
    w_sh_out = 1'b0;
    case (r_op)
      OP_SHL: begin w_sh_nxt = {r_sh[WIDTH-2:0], 1'b0};          w_sh_out = r_sh[WIDTH-1]; end
      OP_SHR: begin w_sh_nxt = {1'b0, r_sh[WIDTH-1:1]};          w_sh_out = r_sh[0];       end
      OP_SAR: begin w_sh_nxt = {r_sh[WIDTH-1], r_sh[WIDTH-1:1]}; w_sh_out = r_sh[0];       end
      OP_ROL: begin w_sh_nxt = {r_sh[WIDTH-2:0], r_sh[WIDTH-1]}; w_sh_out = r_sh[WIDTH-1]; end
      default: begin w_sh_nxt = r_sh; w_sh_out = 1'b0; end
    endcase
  end

  // One shift-add multiply step: conditionally add multiplicand into the high half, then shift right
  always_comb begin
    w_msum     = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
    w_prod_nxt = {w_msum, r_prod[WIDTH-1:1]};
  end

  // FSM next state and completion decode
  always_comb begin
    w_state_nxt = r_state;
    w_fin       = 1'b0;
    w_res       = r_result;
    w_c         = 1'b0;
    w_v         = 1'b0;
    w_load_sh   = 1'b0;
    w_load_mul  = 1'b0;
    case (r_state)
      IDLE: begin
        if (alu_if.Start) begin
          if (w_is_shift && (w_cnt != '0)) begin
            w_state_nxt = SHIFT;
            w_load_sh   = 1'b1;
          end else if (w_is_mul) begin
            w_state_nxt = MUL;
            w_load_mul  = 1'b1;
          end else begin
            w_fin = 1'b1;
            w_res = w_alu_res;
            w_c   = w_alu_c;
            w_v   = w_alu_v;
          end
        end
      end
      SHIFT: begin
        if (r_cnt == CNT_ONE) begin
          w_state_nxt = IDLE;
          w_fin       = 1'b1;
          w_res       = w_sh_nxt;
          w_c         = w_sh_out;
        end
      end
      MUL: begin
        if (r_cnt == CNT_ONE) begin
          w_state_nxt = IDLE;
          w_fin       = 1'b1;
          if (r_op == OP_MULH) begin
            w_res = w_prod_nxt[2*WIDTH-1:WIDTH];
          end else begin
            w_res = w_prod_nxt[WIDTH-1:0];
            w_c   = |w_prod_nxt[2*WIDTH-1:WIDTH];
            w_v   = |w_prod_nxt[2*WIDTH-1:WIDTH];
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Architectural result/flags: written only on a completion edge
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      r_done   <= 1'b0;
      r_result <= '0;
      r_zro    <= 1'b0;
      r_neg    <= 1'b0;
      r_carry  <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_done <= w_fin;
      if (w_fin) begin
        r_result <= w_res;
        r_zro    <= (w_res == '0);
        r_neg    <= w_res[WIDTH-1];
        r_carry  <= w_c;
        r_ovf    <= w_v;
      end
    end
  end

  // Iteration working state: shift register, product register, step counter
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      r_op    <= '0;
      r_sh    <= '0;
      r_cnt   <= '0;
      r_prod  <= '0;
      r_mcand <= '0;
    end else if (w_load_sh) begin
      r_op  <= alu_if.Op;
      r_sh  <= w_a;
      r_cnt <= {1'b0, w_cnt};
    end else if (w_load_mul) begin
      r_op    <= alu_if.Op;
      r_prod  <= {{WIDTH{1'b0}}, w_b};
      r_mcand <= w_a;
      r_cnt   <= CNT_MUL;
    end else if (r_state == SHIFT) begin
      r_sh  <= w_sh_nxt;
      r_cnt <= r_cnt - CNT_ONE;
    end else if (r_state == MUL) begin
      r_prod <= w_prod_nxt;
      r_cnt  <= r_cnt - CNT_ONE;
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=16 with hand-computed expectations.
// Inputs driven 1 time unit after the rising edge; outputs sampled there too.
// Flags are compared as the packed nibble {Z,N,C,V}.
module tb_alu_seq;
  localparam logic [3:0] ADD = 4'd0,  ADC = 4'd1,  SUB = 4'd2,  SBB = 4'd3;
  localparam logic [3:0] AND_ = 4'd4, OR_ = 4'd5,  XOR_ = 4'd6, NOTA = 4'd7;
  localparam logic [3:0] PASSB = 4'd8, SHL = 4'd9, SHR = 4'd10, SAR = 4'd11;
  localparam logic [3:0] ROL = 4'd12, MUL = 4'd13, MULH = 4'd14, RSV = 4'd15;

  logic Clk;
  logic Reset_N;
  int   n_chk;
  int   n_pass;

  alu_seq_if #(.WIDTH(16)) alu_if ();

  alu_seq #(.WIDTH(16), .MUL_EN(1'b1)) dut (
    .Clk     (Clk),
    .Reset_N (Reset_N),
    .alu_if  (alu_if)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  wire [3:0] flg = {alu_if.Zro_Flag, alu_if.Neg_Flag, alu_if.Carry_Flag, alu_if.Ovf_Flag};

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  // Present an op for exactly one rising edge; returns at edge t + 1 time unit
  task automatic start_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    alu_if.Op      = op;
    alu_if.Oprnd_A = a;
    alu_if.Oprnd_B = b;
    alu_if.Start   = 1'b1;
    @(posedge Clk); #1;
    alu_if.Start   = 1'b0;
  endtask

  // Count edges after t until Done, Busy cycles seen, and Result changes before Done
  task automatic wait_done(input logic [15:0] r0, output int lat, output int bsy, output int chg);
    lat = 0; bsy = 0; chg = 0;
    while (!alu_if.Done && lat < 40) begin
      if (alu_if.Busy) bsy++;
      if (alu_if.Result !== r0) chg++;
      @(posedge Clk); #1;
      lat++;
    end
  endtask

  task automatic run(input string tag, input logic [3:0] op, input logic [15:0] a,
                     input logic [15:0] b, input logic [15:0] er, input logic [3:0] ef,
                     input int el);
    logic [15:0] r0;
    int lat, bsy, chg;
    r0 = alu_if.Result;
    start_op(op, a, b);
    wait_done(r0, lat, bsy, chg);
    chk({tag, " latency"}, lat, el);
    chk({tag, " result"}, alu_if.Result, er);
    chk({tag, " flags"}, flg, ef);
    chk({tag, " busy_cycles"}, bsy, el);
    chk({tag, " result_held"}, chg, 0);
    chk({tag, " busy_at_done"}, alu_if.Busy, 1'b0);
    @(posedge Clk); #1;
    chk({tag, " done_one_shot"}, alu_if.Done, 1'b0);
  endtask

  initial begin
    int lat, bsy, chg, ndone;
    n_chk = 0; n_pass = 0;
    Reset_N = 1'b0;
    alu_if.Start = 1'b0; alu_if.Op = '0; alu_if.Oprnd_A = '0; alu_if.Oprnd_B = '0;
    @(posedge Clk); #1;
    chk("rst busy", alu_if.Busy, 1'b0);
    chk("rst done", alu_if.Done, 1'b0);
    chk("rst result", alu_if.Result, 16'h0);
    chk("rst flags", flg, 4'b0000);
    @(posedge Clk); #1;
    Reset_N = 1'b1;
    @(posedge Clk); #1;

    run("add_ovf", ADD, 16'h7FFF, 16'h0001, 16'h8000, 4'b0101, 0);

    // Back-to-back: Start held high across the first Done
    alu_if.Op = ADD; alu_if.Oprnd_A = 16'hFFFF; alu_if.Oprnd_B = 16'h0001; alu_if.Start = 1'b1;
    @(posedge Clk); #1;
    chk("b2b add done", alu_if.Done, 1'b1);
    chk("b2b add result", alu_if.Result, 16'h0000);
    chk("b2b add flags", flg, 4'b1010);
    alu_if.Op = ADC; alu_if.Oprnd_A = 16'h0000; alu_if.Oprnd_B = 16'h0000;
    @(posedge Clk); #1;
    alu_if.Start = 1'b0;
    chk("b2b adc done", alu_if.Done, 1'b1);
    chk("b2b adc result", alu_if.Result, 16'h0001);
    chk("b2b adc flags", flg, 4'b0000);
    @(posedge Clk); #1;
    chk("b2b done_clear", alu_if.Done, 1'b0);

    run("sub_borrow", SUB,   16'h0003, 16'h0005, 16'hFFFE, 4'b0110, 0);
    run("sbb_cin",    SBB,   16'h0000, 16'h0000, 16'hFFFF, 4'b0110, 0);
    run("and",        AND_,  16'hF0F0, 16'hFF00, 16'hF000, 4'b0100, 0);
    run("or",         OR_,   16'h0F00, 16'h00F0, 16'h0FF0, 4'b0000, 0);
    run("xor",        XOR_,  16'hA5A5, 16'hFFFF, 16'h5A5A, 4'b0000, 0);
    run("nota",       NOTA,  16'h00FF, 16'h1234, 16'hFF00, 4'b0100, 0);
    run("passb_zero", PASSB, 16'h1234, 16'h0000, 16'h0000, 4'b1000, 0);
    run("sar3",       SAR,   16'h8001, 16'h0003, 16'hF000, 4'b0100, 3);
    run("shl1",       SHL,   16'h8000, 16'h0001, 16'h0000, 4'b1010, 1);
    run("shr_n0",     SHR,   16'h1234, 16'h0030, 16'h1234, 4'b0000, 0);
    run("rol1",       ROL,   16'h8001, 16'h0001, 16'h0003, 4'b0010, 1);
    run("mul",        MUL,   16'h0100, 16'h0100, 16'h0000, 4'b1011, 16);
    run("mulh",       MULH,  16'h0100, 16'h0100, 16'h0001, 4'b0000, 16);
    run("mulh_max",   MULH,  16'hFFFF, 16'hFFFF, 16'hFFFE, 4'b0100, 16);
    run("reserved",   RSV,   16'h1234, 16'h5678, 16'h0000, 4'b1000, 0);

    // ADD pulsed mid-MUL must be dropped
    start_op(MUL, 16'h0003, 16'h0005);
    repeat (4) begin @(posedge Clk); #1; end
    start_op(ADD, 16'h0001, 16'h0001);
    chk("ignore busy", alu_if.Busy, 1'b1);
    chk("ignore no_done", alu_if.Done, 1'b0);
    wait_done(16'h0000, lat, bsy, chg);
    chk("ignore latency", lat, 11);
    chk("ignore result", alu_if.Result, 16'h000F);
    chk("ignore flags", flg, 4'b0000);
    @(posedge Clk); #1;
    chk("ignore done_clear", alu_if.Done, 1'b0);
    @(posedge Clk); #1;
    chk("ignore no_late_add", alu_if.Done, 1'b0);

    // Asynchronous reset in the middle of a MUL
    run("pre_rst add", ADD, 16'hFFFF, 16'hFFFF, 16'hFFFE, 4'b0110, 0);
    start_op(MUL, 16'h0100, 16'h0100);
    repeat (3) begin @(posedge Clk); #1; end
    #2 Reset_N = 1'b0;
    #1;
    chk("arst busy", alu_if.Busy, 1'b0);
    chk("arst done", alu_if.Done, 1'b0);
    chk("arst result", alu_if.Result, 16'h0000);
    chk("arst flags", flg, 4'b0000);
    @(posedge Clk); #1;
    Reset_N = 1'b1;
    ndone = 0;
    repeat (24) begin
      @(posedge Clk); #1;
      if (alu_if.Done) ndone++;
    end
    chk("arst no_done", ndone, 0);
    chk("arst idle", alu_if.Busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, multi-cycle successor to the core's single-cycle ALU.
- Single-cycle ops: add/subtract with carry, and logic.
- Iterative multi-cycle ops: shifts/rotates, one bit per clock, and shift-add multiply.
- Start/Busy/Done handshake; Result and full flag set (Z/N/C/V) are registered and held until the next completion.
- Sits between the register file operand muxes and the writeback/flag logic of the execute stage.

Parameters:
- WIDTH, 16, datapath width in bits. Must be ≥4 and a power of two.
- MUL_EN, 1, 1 = implement MUL/MULH; 0 = those ops behave as reserved.
- SHW (localparam, not overridable), log2(WIDTH), shift-count field width.

Ports:
- Clk  in  1  rising-edge clock
- Reset_N  in  1  asynchronous, active-low reset
- Start  in  1  request; sampled only when Busy=0
- Op  in  4  operation code, sampled with Start
- Oprnd_A  in  WIDTH  operand A, sampled with Start
- Oprnd_B  in  WIDTH  operand B, or shift count in B[SHW-1:0]; sampled with Start
- Busy  out  1  iterative op in progress
- Done  out  1  one-cycle completion pulse
- Result  out  WIDTH  latched result
- Zro_Flag  out  1  latched zero flag
- Neg_Flag  out  1  latched Result MSB
- Carry_Flag  out  1  latched carry / borrow / shift-out
- Ovf_Flag  out  1  latched signed overflow

Behaviour:
- Reset: one clock, asynchronous and active-low. Reset_N=0 immediately forces state IDLE; Busy, Done, Result, Zro_Flag, Neg_Flag, Carry_Flag and Ovf_Flag all go to 0. Reset mid-operation aborts the op with no Done.
- Op codes:
  - 0 ADD
  - 1 ADC = A+B+Carry_Flag
  - 2 SUB = A-B
  - 3 SBB = A-B-Carry_Flag
  - 4 AND, 5 OR, 6 XOR
  - 7 NOTA
  - 8 PASSB
  - 9 SHL
  - 10 SHR (logical)
  - 11 SAR
  - 12 ROL
  - 13 MUL = low WIDTH bits of unsigned A*B
  - 14 MULH = high WIDTH bits of unsigned A*B
  - 15 reserved: Result=0, Z=1, N=C=V=0
- Arithmetic is computed at WIDTH+1 bits.
  - C on ADD/ADC = carry out.
  - C on SUB/SBB = borrow, i.e. 1 when the unsigned A < B + Cin.
  - V = signed overflow.
- Logic ops and PASSB: C=V=0.
- Shift ops: count n = B[SHW-1:0].
  - C = last bit shifted or rotated out.
  - With n=0: Result=A, C=0.
  - V=0.
- MUL: C=V=1 if the high half is nonzero, else 0. MULH: C=V=0.
- All ops: Z = (Result==0); N = Result[WIDTH-1].
- State machine has states IDLE, SHIFT and MUL.
- IDLE, Start=1 at edge t:
  - Single-cycle op, or shift with n=0: Result and flags are written at edge t and Done=1 for the following cycle. Busy stays 0. State stays IDLE.
  - Shift with n≥1: operands are latched, Busy=1 from edge t, state goes to SHIFT. One bit is processed per edge. Result, flags and Done=1 are written at edge t+n; Busy=0 at the same edge; state returns to IDLE.
  - MUL/MULH: state goes to MUL with a WIDTH-step shift-add on a 2*WIDTH product register. Completion is at edge t+WIDTH, handled the same way as a shift completion.
- Done is high for exactly one cycle per accepted Start.
- Start is accepted whenever Busy=0, including the cycle in which Done=1, so back-to-back ops are allowed.
- Start while Busy=1 is ignored; Op and operands may change freely during Busy.
- Result and flags change only at a completion edge or on reset. The intermediate shift/multiply state is never visible on Result.
- ADC/SBB use the Carry_Flag value latched at the time Start is accepted.
- With MUL_EN=0, ops 13/14 behave as op 15.

Test Plan:
- WIDTH=16, ADD 0x7FFF+0x0001:
  - Result=0x8000, N=1, V=1, C=0, Z=0.
  - Done high exactly the cycle after Start; Busy never asserted.
- ADD 0xFFFF+0x0001, then ADC 0x0000+0x0000 back-to-back (Start held across Done):
  - first op gives Result=0x0000, Z=1, C=1;
  - second op gives Result=0x0001, C=0.
- SUB 0x0003-0x0005:
  - Result=0xFFFE, C=1, N=1, V=0.
  - Then SBB 0x0000-0x0000 gives 0xFFFF, C=1.
- SAR 0x8001 by 3:
  - Busy high for 3 cycles; Done at edge t+3; Result=0xF000, C=0, N=1.
  - SHL 0x8000 by 1 gives 0x0000, Z=1, C=1.
  - SHR with n=0 gives a single-cycle Done and Result=A.
- MUL 0x0100*0x0100:
  - Done at edge t+16; Result=0x0000, Z=1, C=V=1.
  - MULH with the same operands gives 0x0001, C=V=0.
- Start pulsed with ADD during a MUL: ignored; the MUL result is unchanged.
- Reset_N=0 mid-MUL: Busy, Done, Result and all flags drop to 0 immediately, with no clock edge required; no Done afterwards.
